// File: rtl/tcdm_bank_resp_ipa_if.sv
// TCDM request/grant/response bundle for one bank shared by N_PORTS initiators.
// Ports (per initiator, packed arrays indexed by port):
//   req, add[31:0], we (0 = write), wdata[31:0], be[3:0]  initiator -> bank
//   gnt, r_rdata[31:0], r_valid                          bank -> initiator
// Modports: master (initiator side), slave (bank side).
interface tcdm_bank_resp_ipa_if #(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0]       req;
  logic [N_PORTS-1:0][31:0] add;
  logic [N_PORTS-1:0]       we;
  logic [N_PORTS-1:0][31:0] wdata;
  logic [N_PORTS-1:0][3:0]  be;
  logic [N_PORTS-1:0]       gnt;
  logic [N_PORTS-1:0][31:0] r_rdata;
  logic [N_PORTS-1:0]       r_valid;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_rdata, r_valid
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_rdata, r_valid
  );
endinterface

// File: rtl/tcdm_bank_resp_ipa.sv
// Single-port word-addressed SRAM bank answering the TCDM req/gnt/r_valid
// protocol for N_PORTS initiators through a round-robin arbiter.
// At most one grant per cycle (combinational from req); the response
// (r_valid pulse, read data or zero for writes) follows one cycle later.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   tcdm    tcdm_bank_resp_ipa_if.slave bundle (req/add/we/wdata/be in,
//           gnt/r_rdata/r_valid out)
// Optional feature: define TCDM_BANK_STALL_EN to add an 8-bit LFSR that
// randomly withholds all grants (whenever lfsr[0]=1) to stress initiators.
module tcdm_bank_resp_ipa #(
  parameter int N_PORTS    = 4,
  parameter int BANK_DEPTH = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tcdm_bank_resp_ipa_if.slave  tcdm
);
  localparam int AW = $clog2(BANK_DEPTH);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0]      rr_ptr;
  logic               stall_p0;
  logic               found_p0;
  logic [PW-1:0]      sel_p0;
  logic [N_PORTS-1:0] gnt_p0;
  logic [AW-1:0]      word_p0;
  logic [N_PORTS-1:0] vld_p1;
  logic [31:0]        rdata_p1;
  logic [31:0]        mem [BANK_DEPTH];

`ifdef TCDM_BANK_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_p0 = lfsr[0];
`else
  assign stall_p0 = 1'b0;
`endif

  // ---- stage p0: round-robin arbitration, scanning upward from rr_ptr ----
  always_comb begin
    int idx;
    found_p0 = 1'b0;
    sel_p0   = '0;
    gnt_p0   = '0;
    idx      = 0;
    if (!stall_p0) begin
      for (int i = 0; i < N_PORTS; i++) begin
        idx = (int'(rr_ptr) + i) % N_PORTS;
        if (!found_p0 && tcdm.req[idx]) begin
          found_p0 = 1'b1;
          sel_p0   = idx[PW-1:0];
        end
      end
    end
    if (found_p0) gnt_p0[sel_p0] = 1'b1;
  end

  assign tcdm.gnt = gnt_p0;
  // Upper address bits and the byte offset are dropped, so addresses alias.
  assign word_p0  = tcdm.add[sel_p0][AW+1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      vld_p1 <= '0;
    end else begin
      vld_p1 <= gnt_p0;
      if (found_p0)
        rr_ptr <= (sel_p0 == PW'(N_PORTS - 1)) ? '0 : sel_p0 + 1'b1;
    end
  end

  // SRAM array and response data: not reset; outputs are gated by vld_p1.
  always_ff @(posedge clk_i) begin
    if (found_p0) begin
      if (!tcdm.we[sel_p0]) begin
        for (int b = 0; b < 4; b++)
          if (tcdm.be[sel_p0][b])
            mem[word_p0][8*b +: 8] <= tcdm.wdata[sel_p0][8*b +: 8];
        rdata_p1 <= '0;
      end else begin
        rdata_p1 <= mem[word_p0];
      end
    end
  end

  // ---- stage p1: response, only the granted port sees data ----
  always_comb begin
    tcdm.r_rdata = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (vld_p1[i]) tcdm.r_rdata[i] = rdata_p1;
  end

  assign tcdm.r_valid = vld_p1;

endmodule

// File: tb/tb_tcdm_bank_resp_ipa.sv
module tb_tcdm_bank_resp_ipa;
  localparam int NP    = 4;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  tcdm_bank_resp_ipa_if #(.N_PORTS(NP)) bus ();

  tcdm_bank_resp_ipa #(.N_PORTS(NP), .BANK_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tcdm   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    bus.req[p]   = 1'b1;
    bus.we[p]    = we;
    bus.add[p]   = a;
    bus.wdata[p] = wd;
    bus.be[p]    = be;
  endtask

  // One isolated transaction: grant checked in the request cycle, response
  // checked one cycle later, r_valid checked low before the request.
  task automatic xact(input string tag, input int p, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    logic [3:0]   g;
    logic [127:0] d;
    g = 4'b0001 << p;
    d = {96'h0, exp} << (32 * p);
    @(negedge clk);
    set_port(p, we, a, wd, be);
    #1;
    chk({tag, "_idle_rvalid"}, bus.r_valid, 0);
    chk({tag, "_gnt"}, bus.gnt, g);
    @(negedge clk);
    bus.req = '0;
    #1;
    chk({tag, "_rvalid"}, bus.r_valid, g);
    chk({tag, "_rdata"}, bus.r_rdata, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.we    = '1;
    bus.add   = '0;
    bus.wdata = '0;
    bus.be    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", bus.r_valid, 0);
    chk("rst_rdata", bus.r_rdata, 0);
    chk("rst_gnt_noreq", bus.gnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TCDM_BANK_STALL_EN
    begin
      logic [7:0] m;
      int         exp_cnt;
      int         got_cnt;
      logic       prev;
      m       = 8'hA5;
      exp_cnt = 0;
      got_cnt = 0;
      prev    = 1'b0;
      set_port(1, 1'b0, 32'h40, 32'h0, 4'h0);
      for (int c = 0; c < 64; c++) begin
        #1;
        chk("stall_gnt", bus.gnt, m[0] ? 4'b0000 : 4'b0010);
        chk("stall_rvalid", bus.r_valid, prev ? 4'b0010 : 4'b0000);
        if (!m[0]) exp_cnt++;
        if (bus.gnt == 4'b0010) got_cnt++;
        prev = !m[0];
        @(negedge clk);
        m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      end
      bus.req = '0;
      chk("stall_count", got_cnt, exp_cnt);
    end
`else
    // Write then read back.
    xact("t1_wr", 0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    xact("t1_rd", 0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    // Byte-enabled partial write.
    xact("t2_wr1", 1, 1'b0, 32'h20, 32'h11223344, 4'hF, 32'h0);
    xact("t2_wr2", 1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0);
    xact("t2_rd", 1, 1'b1, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);
    // Address aliasing, upper bits and byte offset ignored.
    xact("t4_wr", 3, 1'b0, 32'h0, 32'h5A5A5A5A, 4'hF, 32'h0);
    xact("t4_rd_alias", 3, 1'b1, DEPTH * 4, 32'h0, 4'h0, 32'h5A5A5A5A);
    xact("t4_rd_off", 2, 1'b1, 32'hFFFF_F003, 32'h0, 4'h0, 32'h5A5A5A5A);
    // be=0 write: handshake happens, data untouched.
    xact("t7_wr_be0", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0);
    xact("t7_rd", 0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

    // All four ports request from reset: 0,1,2,3,0 back-to-back.
    do_reset();
    begin
      logic [3:0]  gseq [5];
      logic [31:0] pdat [4];
      int          pseq [5];
      gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pseq = '{0, 1, 2, 3, 0};
      pdat = '{32'hDEADBEEF, 32'h11BB33DD, 32'h5A5A5A5A, 32'h5A5A5A5A};
      set_port(0, 1'b1, 32'h10, 32'h0, 4'h0);
      set_port(1, 1'b1, 32'h20, 32'h0, 4'h0);
      set_port(2, 1'b1, 32'h0, 32'h0, 4'h0);
      set_port(3, 1'b1, 32'h1000, 32'h0, 4'h0);
      for (int c = 0; c < 6; c++) begin
        if (c == 5) bus.req = '0;
        #1;
        if (c < 5) chk("t3_gnt", bus.gnt, gseq[c]);
        else       chk("t3_gnt_none", bus.gnt, 0);
        if (c > 0) begin
          chk("t3_rvalid", bus.r_valid, gseq[c-1]);
          chk("t3_rdata", bus.r_rdata, {96'h0, pdat[pseq[c-1]]} << (32 * pseq[c-1]));
        end else begin
          chk("t3_rvalid_first", bus.r_valid, 0);
        end
        @(negedge clk);
      end
    end

    // Reset while a read response is pending (rr_ptr is 1 here).
    set_port(2, 1'b1, 32'h20, 32'h0, 4'h0);
    #1;
    chk("t5_gnt", bus.gnt, 4'b0100);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("t5_rvalid_in_rst", bus.r_valid, 0);
    chk("t5_rdata_in_rst", bus.r_rdata, 0);
    @(negedge clk);
    #1;
    chk("t5_rvalid_held", bus.r_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_rvalid_release", bus.r_valid, 0);
    @(negedge clk);
    #1;
    chk("t5_rvalid_after", bus.r_valid, 0);
    set_port(0, 1'b1, 32'h10, 32'h0, 4'h0);
    set_port(1, 1'b1, 32'h20, 32'h0, 4'h0);
    set_port(2, 1'b1, 32'h0, 32'h0, 4'h0);
    set_port(3, 1'b1, 32'h0, 32'h0, 4'h0);
    #1;
    chk("t5_rrptr_zero", bus.gnt, 4'b0001);
    @(negedge clk);
    bus.req = '0;
    #1;
    chk("t5_rvalid", bus.r_valid, 4'b0001);
    chk("t5_rdata", bus.r_rdata, {96'h0, 32'hDEADBEEF});
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
